sha256_block_sequencer: RTL and testbench
=========================================

// Module: sha256_block_sequencer
// PURPOSE
//  Controller sitting between the host message interface, the SHA-256 padder and the
//  SHA-256 compression core. Per message: enables the padder, waits for padding done,
//  fetches each 512-bit block (1..3) by id, feeds it to the core and chains the hash,
//  then presents the 256-bit digest. Owns the padder load handshake and a watchdog.
// PARAMETERS
//  TIMEOUT_CYCLES  1024  max cycles in any wait state before error abort
//  TMR_W           11    timer width; must satisfy 2**TMR_W > TIMEOUT_CYCLES
// PORTS
//  iClk           in   1    clock
//  iRst_n         in   1    synchronous active-low reset
//  iStart         in   1    start pulse; sampled only in IDLE
//  oBusy          out  1    high in every state except IDLE
//  oDone          out  1    1-cycle pulse, digest valid
//  oError         out  1    1-cycle pulse, abort (timeout or bad block count)
//  oDigest        out  256  final hash; held until next oDone
//  oPadEnable     out  1    padder enable (low = padder held in reset)
//  oPadLoad       out  1    padder block-load request
//  oPadIdBlock    out  2    requested block id, 1..3
//  iPadDone       in   1    padder finished padding (level)
//  iPadDataValid  in   1    padder block valid (1-cycle pulse)
//  iPadBlock      in   512  padder block data
//  iPadNumBlock   in   2    block count from padder, valid once iPadDone=1
//  oCoreStart     out  1    1-cycle pulse, compress oCoreBlock
//  oCoreFirst     out  1    qualifies oCoreStart: load IV before compressing
//  oCoreBlock     out  512  registered block to core
//  iCoreDone      in   1    1-cycle pulse, compression complete
//  iCoreDigest    in   256  core running hash, valid with iCoreDone
// BEHAVIOUR
//  Clock/reset: one clock iClk; reset iRst_n is synchronous, active-low.
//  Reset: state=IDLE; all outputs 0 (oDigest=0, oCoreBlock=0); timer=0; blk=0; nblk=0.
//  FSM:
//   IDLE: iStart=1 -> PAD_WAIT, oPadEnable<=1, timer<=0, blk<=1.
//   PAD_WAIT: on iPadDone=1, latch nblk<=iPadNumBlock.
//     nblk==0 -> ERROR; else -> LOAD_REQ.
//   LOAD_REQ: oPadIdBlock<=blk, oPadLoad<=1 -> LOAD_WAIT.
//   LOAD_WAIT: hold oPadLoad=1 until iPadDataValid=1; same cycle latch
//     oCoreBlock<=iPadBlock, oPadLoad<=0 -> CORE_START.
//     oPadLoad must be low the cycle after valid so the padder parks.
//   CORE_START: oCoreStart=1 one cycle, oCoreFirst=(blk==1) -> CORE_WAIT.
//   CORE_WAIT: on iCoreDone=1:
//     blk==nblk -> FINISH, oDigest<=iCoreDigest;
//     else blk<=blk+1 -> LOAD_REQ.
//   FINISH: oDone=1 one cycle, oPadEnable<=0 -> IDLE.
//   ERROR: oError=1 one cycle, oPadEnable<=0, oPadLoad<=0 -> IDLE.
//  Watchdog:
//   - timer clears on every state entry and counts in PAD_WAIT, LOAD_WAIT and CORE_WAIT.
//   - timer==TIMEOUT_CYCLES-1 without the awaited event -> ERROR.
//   - If the event arrives in that same cycle, the event wins.
//  Boundary conditions:
//   - iStart outside IDLE is ignored.
//   - iPadDataValid or iCoreDone outside their wait states is ignored.
//   - oPadEnable stays high from IDLE exit until FINISH/ERROR; padder state persists
//     across all block fetches.
//   - Spurious iCoreDone in LOAD_WAIT is dropped.
//   - oDigest is not updated on ERROR.
//   - Reset mid-operation returns to IDLE within one clock, all outputs 0, no oDone/oError.
//  Latency (ideal responders; padder valid 2 cycles after load, core done after C cycles):
//   - per block: LOAD_REQ..CORE_START = 4 cycles, plus C;
//   - total = pad time + nblk*(4+C) + 1.
// TESTING
//  1) Msg "abc", nblk=1 -> one oPadLoad with id 1, oCoreFirst=1, oDone once,
//     oDigest=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
//  2) Padder reports nblk=3 -> ids 1,2,3 requested in order.
//     oCoreFirst is high only on block 1; oDone after third iCoreDone.
//  3) nblk=0 with iPadDone -> oError pulse, oPadEnable low next cycle, back in IDLE.
//  4) Core never asserts iCoreDone -> oError exactly TIMEOUT_CYCLES cycles after
//     CORE_WAIT entry; oDigest unchanged.
//  5) iStart pulsed in CORE_WAIT, plus spurious iPadDataValid -> no effect on sequence/digest.
//  6) iRst_n low during LOAD_WAIT of block 2 -> next cycle IDLE, all outputs 0;
//     a new iStart then completes normally.

Source files
------------

// File: rtl/sha256_block_sequencer.sv
// SHA-256 message sequencer: drives the padder, fetches padded blocks one by one,
// feeds them to the compression core, and publishes the chained digest.
module sha256_block_sequencer #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TMR_W          = 11
) (
    input  logic         iClk,
    input  logic         iRst_n,
    input  logic         iStart,
    output logic         oBusy,
    output logic         oDone,
    output logic         oError,
    output logic [255:0] oDigest,
    output logic         oPadEnable,
    output logic         oPadLoad,
    output logic [1:0]   oPadIdBlock,
    input  logic         iPadDone,
    input  logic         iPadDataValid,
    input  logic [511:0] iPadBlock,
    input  logic [1:0]   iPadNumBlock,
    output logic         oCoreStart,
    output logic         oCoreFirst,
    output logic [511:0] oCoreBlock,
    input  logic         iCoreDone,
    input  logic [255:0] iCoreDigest
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        PAD_WAIT   = 3'd1,
        LOAD_REQ   = 3'd2,
        LOAD_WAIT  = 3'd3,
        CORE_START = 3'd4,
        CORE_WAIT  = 3'd5,
        FINISH     = 3'd6,
        ERROR      = 3'd7
    } state_t;

    localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    state_t             state,      nextState;
    logic [TMR_W-1:0]   timer,      nextTimer;
    logic [1:0]         blk,        nextBlk;
    logic [1:0]         nblk,       nextNblk;
    logic               busy,       nextBusy;
    logic               done,       nextDone;
    logic               error,      nextError;
    logic [255:0]       digest,     nextDigest;
    logic               padEnable,  nextPadEnable;
    logic               padLoad,    nextPadLoad;
    logic [1:0]         padIdBlock, nextPadIdBlock;
    logic               coreStart,  nextCoreStart;
    logic               coreFirst,  nextCoreFirst;
    logic [511:0]       coreBlock,  nextCoreBlock;
    logic               timedOut;
    logic               waitState;

    assign timedOut  = (timer == TIMEOUT_LAST);
    assign waitState = (state == PAD_WAIT) || (state == LOAD_WAIT) || (state == CORE_WAIT);

    // Next-state and next-output logic; every output is registered from these values.
    always_comb begin
        nextState      = state;
        nextTimer      = timer;
        nextBlk        = blk;
        nextNblk       = nblk;
        nextDone       = 1'b0;
        nextError      = 1'b0;
        nextDigest     = digest;
        nextPadEnable  = padEnable;
        nextPadLoad    = padLoad;
        nextPadIdBlock = padIdBlock;
        nextCoreStart  = 1'b0;
        nextCoreFirst  = coreFirst;
        nextCoreBlock  = coreBlock;
        case (state)
            IDLE: begin
                if (iStart) begin
                    nextState     = PAD_WAIT;
                    nextPadEnable = 1'b1;
                    nextBlk       = 2'd1;
                end else begin
                    nextState = IDLE;
                end
            end
            PAD_WAIT: begin
                if (iPadDone) begin
                    nextNblk = iPadNumBlock;
                    if (iPadNumBlock == 2'd0) begin
                        nextState = ERROR;
                        nextError = 1'b1;
                    end else begin
                        nextState = LOAD_REQ;
                    end
                end else if (timedOut) begin
                    nextState = ERROR;
                    nextError = 1'b1;
                end else begin
                    nextState = PAD_WAIT;
                end
            end
            LOAD_REQ: begin
                nextPadIdBlock = blk;
                nextPadLoad    = 1'b1;
                nextState      = LOAD_WAIT;
            end
            LOAD_WAIT: begin
                // Load drops together with the capture so the padder parks next cycle.
                if (iPadDataValid) begin
                    nextCoreBlock = iPadBlock;
                    nextPadLoad   = 1'b0;
                    nextCoreStart = 1'b1;
                    nextCoreFirst = (blk == 2'd1);
                    nextState     = CORE_START;
                end else if (timedOut) begin
                    nextState = ERROR;
                    nextError = 1'b1;
                end else begin
                    nextState = LOAD_WAIT;
                end
            end
            CORE_START: begin
                nextCoreFirst = 1'b0;
                nextState     = CORE_WAIT;
            end
            CORE_WAIT: begin
                if (iCoreDone) begin
                    if (blk == nblk) begin
                        nextDigest = iCoreDigest;
                        nextDone   = 1'b1;
                        nextState  = FINISH;
                    end else begin
                        nextBlk   = blk + 2'd1;
                        nextState = LOAD_REQ;
                    end
                end else if (timedOut) begin
                    nextState = ERROR;
                    nextError = 1'b1;
                end else begin
                    nextState = CORE_WAIT;
                end
            end
            FINISH: begin
                nextPadEnable = 1'b0;
                nextState     = IDLE;
            end
            ERROR: begin
                nextPadEnable = 1'b0;
                nextPadLoad   = 1'b0;
                nextState     = IDLE;
            end
            default: begin
                nextState     = IDLE;
                nextPadEnable = 1'b0;
                nextPadLoad   = 1'b0;
            end
        endcase

        if (nextState != state) begin
            nextTimer = {TMR_W{1'b0}};
        end else if (waitState) begin
            nextTimer = timer + {{(TMR_W-1){1'b0}}, 1'b1};
        end else begin
            nextTimer = timer;
        end
        nextBusy = (nextState != IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            state      <= IDLE;
            timer      <= {TMR_W{1'b0}};
            blk        <= 2'd0;
            nblk       <= 2'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            digest     <= {256{1'b0}};
            padEnable  <= 1'b0;
            padLoad    <= 1'b0;
            padIdBlock <= 2'd0;
            coreStart  <= 1'b0;
            coreFirst  <= 1'b0;
            coreBlock  <= {512{1'b0}};
        end else begin
            state      <= nextState;
            timer      <= nextTimer;
            blk        <= nextBlk;
            nblk       <= nextNblk;
            busy       <= nextBusy;
            done       <= nextDone;
            error      <= nextError;
            digest     <= nextDigest;
            padEnable  <= nextPadEnable;
            padLoad    <= nextPadLoad;
            padIdBlock <= nextPadIdBlock;
            coreStart  <= nextCoreStart;
            coreFirst  <= nextCoreFirst;
            coreBlock  <= nextCoreBlock;
        end
    end

    assign oBusy       = busy;
    assign oDone       = done;
    assign oError      = error;
    assign oDigest     = digest;
    assign oPadEnable  = padEnable;
    assign oPadLoad    = padLoad;
    assign oPadIdBlock = padIdBlock;
    assign oCoreStart  = coreStart;
    assign oCoreFirst  = coreFirst;
    assign oCoreBlock  = coreBlock;

endmodule

// File: tb/tb_sha256_block_sequencer.sv
// Directed bench for sha256_block_sequencer: the bench plays padder and core,
// and every expectation is a hand-derived constant.
module tb_sha256_block_sequencer;

    localparam int TIMEOUT_CYCLES = 1024;

    logic         iClk;
    logic         iRst_n;
    logic         iStart;
    logic         oBusy;
    logic         oDone;
    logic         oError;
    logic [255:0] oDigest;
    logic         oPadEnable;
    logic         oPadLoad;
    logic [1:0]   oPadIdBlock;
    logic         iPadDone;
    logic         iPadDataValid;
    logic [511:0] iPadBlock;
    logic [1:0]   iPadNumBlock;
    logic         oCoreStart;
    logic         oCoreFirst;
    logic [511:0] oCoreBlock;
    logic         iCoreDone;
    logic [255:0] iCoreDigest;

    int checks = 0;
    int errors = 0;

    localparam logic [255:0] ABC_DIGEST =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [511:0] ABC_BLOCK = {32'h61626380, 448'd0, 32'h00000018};
    localparam logic [511:0] BLK1 = {16{32'h11111111}};
    localparam logic [511:0] BLK2 = {16{32'h22222222}};
    localparam logic [511:0] BLK3 = {16{32'h33333333}};
    localparam logic [255:0] DIG1 = {8{32'hd1d1d1d1}};
    localparam logic [255:0] DIG2 = {8{32'hd2d2d2d2}};
    localparam logic [255:0] DIG3 = {8{32'hd3d3d3d3}};

    sha256_block_sequencer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .TMR_W(11)) dut (
        .iClk(iClk), .iRst_n(iRst_n), .iStart(iStart),
        .oBusy(oBusy), .oDone(oDone), .oError(oError), .oDigest(oDigest),
        .oPadEnable(oPadEnable), .oPadLoad(oPadLoad), .oPadIdBlock(oPadIdBlock),
        .iPadDone(iPadDone), .iPadDataValid(iPadDataValid), .iPadBlock(iPadBlock),
        .iPadNumBlock(iPadNumBlock), .oCoreStart(oCoreStart), .oCoreFirst(oCoreFirst),
        .oCoreBlock(oCoreBlock), .iCoreDone(iCoreDone), .iCoreDigest(iCoreDigest)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic startMsg(input logic [1:0] num);
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
        check("busyAfterStart", 512'(oBusy), 512'(1'b1));
        check("padEnAfterStart", 512'(oPadEnable), 512'(1'b1));
        tick();
        tick();
        iPadDone     = 1'b1;
        iPadNumBlock = num;
    endtask

    task automatic waitLoad();
        int n = 0;
        while (oPadLoad !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check("waitLoad", 512'(oPadLoad), 512'(1'b1));
    endtask

    // Plays one block fetch and compression; c == 0 leaves the core silent.
    task automatic doBlock(input logic [1:0] id, input logic [511:0] blkData,
                           input logic [255:0] dig, input int c, input bit spur, input bit last);
        waitLoad();
        check("padId", 512'(oPadIdBlock), 512'(id));
        if (spur) begin
            iCoreDone   = 1'b1;
            iCoreDigest = ~dig;
            tick();
            iCoreDone = 1'b0;
            check("loadHeld", 512'(oPadLoad), 512'(1'b1));
        end else begin
            tick();
        end
        iPadDataValid = 1'b1;
        iPadBlock     = blkData;
        tick();
        iPadDataValid = 1'b0;
        check("coreStart", 512'(oCoreStart), 512'(1'b1));
        check("loadDropped", 512'(oPadLoad), 512'(1'b0));
        check("coreBlock", oCoreBlock, blkData);
        check("coreFirst", 512'(oCoreFirst), 512'(id == 2'd1));
        tick();
        check("coreStartPulse", 512'(oCoreStart), 512'(1'b0));
        if (c > 0) begin
            for (int k = 0; k < c - 1; k++) begin
                if (spur && k == 0) begin
                    iStart        = 1'b1;
                    iPadDataValid = 1'b1;
                    iPadBlock     = ~blkData;
                end
                tick();
                iStart        = 1'b0;
                iPadDataValid = 1'b0;
            end
            if (spur) begin
                check("spurBlock", oCoreBlock, blkData);
                check("spurLoad", 512'(oPadLoad), 512'(1'b0));
            end
            iCoreDone   = 1'b1;
            iCoreDigest = dig;
            tick();
            iCoreDone = 1'b0;
            check("donePulse", 512'(oDone), 512'(last));
        end
    endtask

    task automatic finishMsg(input logic [255:0] expDigest);
        check("digest", 512'(oDigest), 512'(expDigest));
        iPadDone = 1'b0;
        tick();
        check("doneOneCycle", 512'(oDone), 512'(1'b0));
        check("idleBusy", 512'(oBusy), 512'(1'b0));
        check("idlePadEn", 512'(oPadEnable), 512'(1'b0));
    endtask

    initial begin
        int early;
        iRst_n = 1'b0; iStart = 1'b0; iPadDone = 1'b0; iPadDataValid = 1'b0;
        iPadBlock = '0; iPadNumBlock = 2'd0; iCoreDone = 1'b0; iCoreDigest = '0;
        tick(); tick(); tick();
        check("rstBusy", 512'(oBusy), 512'(1'b0));
        check("rstPadEn", 512'(oPadEnable), 512'(1'b0));
        check("rstDigest", 512'(oDigest), 512'(0));
        check("rstCoreBlock", oCoreBlock, 512'(0));
        iRst_n = 1'b1;
        tick();

        // 1) single-block "abc"
        startMsg(2'd1);
        doBlock(2'd1, ABC_BLOCK, ABC_DIGEST, 4, 1'b0, 1'b1);
        finishMsg(ABC_DIGEST);

        // 2) three blocks, ids in order, first only on block 1
        startMsg(2'd3);
        doBlock(2'd1, BLK1, DIG1, 3, 1'b0, 1'b0);
        doBlock(2'd2, BLK2, DIG2, 2, 1'b0, 1'b0);
        doBlock(2'd3, BLK3, DIG3, 5, 1'b0, 1'b1);
        finishMsg(DIG3);

        // 3) zero block count aborts
        startMsg(2'd0);
        tick();
        check("nblk0Error", 512'(oError), 512'(1'b1));
        check("nblk0Done", 512'(oDone), 512'(1'b0));
        iPadDone = 1'b0;
        tick();
        check("nblk0ErrPulse", 512'(oError), 512'(1'b0));
        check("nblk0PadEn", 512'(oPadEnable), 512'(1'b0));
        check("nblk0Idle", 512'(oBusy), 512'(1'b0));
        check("nblk0Digest", 512'(oDigest), 512'(DIG3));

        // 4) core silent -> watchdog exactly TIMEOUT_CYCLES after CORE_WAIT entry
        startMsg(2'd1);
        doBlock(2'd1, BLK1, DIG1, 0, 1'b0, 1'b0);
        early = 0;
        for (int k = 1; k < TIMEOUT_CYCLES; k++) begin
            tick();
            if (oError !== 1'b0) early++;
        end
        check("noEarlyTimeout", 512'(early), 512'(0));
        tick();
        check("timeoutError", 512'(oError), 512'(1'b1));
        check("timeoutDigest", 512'(oDigest), 512'(DIG3));
        iPadDone = 1'b0;
        tick();
        check("timeoutPadEn", 512'(oPadEnable), 512'(1'b0));
        check("timeoutIdle", 512'(oBusy), 512'(1'b0));

        // 5) spurious start / valid / core done are ignored
        startMsg(2'd2);
        doBlock(2'd1, BLK2, DIG2, 3, 1'b1, 1'b0);
        doBlock(2'd2, BLK3, DIG1, 3, 1'b1, 1'b1);
        finishMsg(DIG1);

        // 6) reset during LOAD_WAIT of block 2, then a clean run
        startMsg(2'd3);
        doBlock(2'd1, BLK1, DIG1, 2, 1'b0, 1'b0);
        waitLoad();
        check("rst6Id", 512'(oPadIdBlock), 512'(2'd2));
        iRst_n = 1'b0;
        tick();
        iRst_n   = 1'b1;
        iPadDone = 1'b0;
        check("rst6Busy", 512'(oBusy), 512'(1'b0));
        check("rst6Load", 512'(oPadLoad), 512'(1'b0));
        check("rst6PadEn", 512'(oPadEnable), 512'(1'b0));
        check("rst6Digest", 512'(oDigest), 512'(0));
        check("rst6CoreBlock", oCoreBlock, 512'(0));
        check("rst6DoneErr", 512'({oDone, oError}), 512'(2'b00));
        tick();
        startMsg(2'd1);
        doBlock(2'd1, ABC_BLOCK, ABC_DIGEST, 3, 1'b0, 1'b1);
        finishMsg(ABC_DIGEST);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
